// File: rtl/gray_conv_pkg.sv
// Shared types for the Gray-code conversion arbiter:
// output-stage FSM states and conversion mode encodings.
package gray_conv_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

endpackage

// File: rtl/gray_xlate.sv
// Combinational binary<->Gray converter shared by all requesters.
// mode selects direction: MODE_B2G or MODE_G2B.
module gray_xlate
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] word,
    input  logic             mode,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] g2b;

    assign b2g = word ^ (word >> 1);

    // Gray->binary is a prefix XOR running from the MSB down.
    always_comb begin
        g2b = '0;
        g2b[WIDTH-1] = word[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            g2b[i] = g2b[i+1] ^ word[i];
        end
    end

    assign result = (mode == MODE_G2B) ? g2b : b2g;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared Gray converter
// into a single-entry EMPTY/FULL result register.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_mode,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic                      out_mode,
    input  logic                      out_ready
);

    localparam int IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             mode_q, mode_d;

    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   idx;
    logic             found;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_word;
    logic             sel_mode;
    logic [WIDTH-1:0] xlated;

    // NREQ is a power of two, so the IDW-bit add wraps modulo NREQ.
    always_comb begin
        grant_id = rr_ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = rr_ptr_q + IDW'(off);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
    end

    assign can_load = rst_n && (state_q == EMPTY || out_ready);
    assign accept   = can_load && found;

    assign req_ready = accept
        ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id)
        : '0;

    assign sel_word = req_data[grant_id*WIDTH +: WIDTH];
    assign sel_mode = req_mode[grant_id];

    gray_xlate #(
        .WIDTH (WIDTH)
    ) u_xlate (
        .word   (sel_word),
        .mode   (sel_mode),
        .result (xlated)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        id_d     = id_q;
        mode_d   = mode_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (out_ready && !accept) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            rr_ptr_d = grant_id + IDW'(1);
            data_d   = xlated;
            id_d     = grant_id;
            mode_d   = sel_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            data_q   <= '0;
            id_q     <= '0;
            mode_q   <= MODE_B2G;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            id_q     <= id_d;
            mode_q   <= mode_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign out_mode  = mode_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed vector bench for gray_conv_arbiter (WIDTH=4, NREQ=4).
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_gray_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_mode;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_mode;
    logic        out_ready;

    int nchecks = 0;
    int nerrors = 0;

    gray_conv_arbiter #(
        .WIDTH (4),
        .NREQ  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_mode  (out_mode),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  mode;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [3:0]  e_od;
        logic [1:0]  e_id;
        logic        e_om;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] m,
                         input logic [15:0] d, input logic r);
        req_valid = v;
        req_mode  = m;
        req_data  = d;
        out_ready = r;
    endtask

    logic [1:0] seq_id[5];
    logic [3:0] seq_od[5];

    initial begin
        vecs[0]  = '{4'b0001, 4'b0000, 16'h000B, 1'b1, 4'b0001, 1'b1, 4'hE, 2'd0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 16'h0E00, 1'b1, 4'b0100, 1'b1, 4'hB, 2'd2, 1'b1};
        vecs[2]  = '{4'b1000, 4'b0000, 16'hF000, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0};
        vecs[4]  = '{4'b0000, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0};
        vecs[5]  = '{4'b0010, 4'b0000, 16'h0000, 1'b0, 4'b0010, 1'b1, 4'h0, 2'd1, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0000, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h0, 2'd1, 1'b0};
        vecs[7]  = '{4'b1111, 4'b0000, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h0, 2'd1, 1'b0};
        vecs[8]  = '{4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h2, 2'd2, 1'b0};
        vecs[9]  = '{4'b0011, 4'b0000, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0};
        vecs[10] = '{4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1, 1'b1};
        vecs[12] = '{4'b0001, 4'b0000, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1, 1'b1};
        vecs[13] = '{4'b1001, 4'b0000, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h6, 2'd3, 1'b0};

        seq_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq_od = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h1};

        // Reset with every requester asking: nothing may be granted.
        rst_n = 1'b0;
        drive(4'b1111, 4'b0000, 16'h4321, 1'b1);
        @(negedge clk);
        #1 check("rst_req_ready", 16'(req_ready), 16'h0);
        @(posedge clk);
        #1;
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_data", 16'(out_data), 16'h0);
        check("rst_out_id", 16'(out_id), 16'h0);
        check("rst_out_mode", 16'(out_mode), 16'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].valid, vecs[i].mode, vecs[i].data, vecs[i].ordy);
            #1 check($sformatf("v%0d_req_ready", i),
                     16'(req_ready), 16'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i),
                  16'(out_valid), 16'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_out_data", i),
                      16'(out_data), 16'(vecs[i].e_od));
                check($sformatf("v%0d_out_id", i),
                      16'(out_id), 16'(vecs[i].e_id));
                check($sformatf("v%0d_out_mode", i),
                      16'(out_mode), 16'(vecs[i].e_om));
            end
            @(negedge clk);
        end

        // All four requesting back to back: one result per cycle, wrapping.
        drive(4'b1111, 4'b0000, 16'h4321, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_out_valid", c), 16'(out_valid), 16'h1);
            check($sformatf("rr%0d_out_id", c), 16'(out_id), 16'(seq_id[c]));
            check($sformatf("rr%0d_out_data", c), 16'(out_data), 16'(seq_od[c]));
        end

        // Mid-operation reset while FULL with a non-zero pointer.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("mrst_req_ready", 16'(req_ready), 16'h0);
        @(posedge clk);
        #1;
        check("mrst_out_valid", 16'(out_valid), 16'h0);
        check("mrst_out_data", 16'(out_data), 16'h0);
        check("mrst_out_id", 16'(out_id), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_req_ready", 16'(req_ready), 16'b0001);
        @(posedge clk);
        #1;
        check("post_rst_out_valid", 16'(out_valid), 16'h1);
        check("post_rst_out_id", 16'(out_id), 16'h0);
        check("post_rst_out_data", 16'(out_data), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 4, code word width in bits (>=2)
  NREQ, 4, number of requesters (power of two, 2..8)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state updates on rising edge
  rst_n  input  1  reset; synchronous, active-low
  req_valid  input  NREQ  per-requester request valid
  req_mode  input  NREQ  per-requester mode: 0 = binary->Gray, 1 = Gray->binary
  req_data  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
  req_ready  output  NREQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i]
  out_valid  output  1  result register holds a valid result
  out_data  output  WIDTH  converted word
  out_id  output  log2(NREQ)  index of the requester that produced out_data
  out_mode  output  1  mode used for out_data
  out_ready  input  1  consumer accepts result when out_valid & out_ready

Function
REQ-003 A single shared converter SHALL serve all requesters; at most one request SHALL be accepted per cycle.
REQ-004 Binary->Gray: g[W-1]=b[W-1]; g[i]=b[i+1]^b[i] for i<W-1.
REQ-005 Gray->binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i], MSB to LSB.
REQ-006 The output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-007 Transitions: EMPTY, any valid -> FULL (load); FULL, !out_ready -> FULL (hold, outputs stable); FULL, out_ready, any valid -> FULL (load new); FULL, out_ready, no valid -> EMPTY.
REQ-008 req_ready SHALL be all-zero unless (state==EMPTY or out_ready==1); otherwise it SHALL be one-hot on the granted valid requester, or all-zero if none valid.
REQ-009 req_ready MAY depend combinationally on req_valid and out_ready; no other combinational input-to-output path SHALL exist.
REQ-010 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, ascending modulo NREQ; first valid requester wins.
REQ-011 On acceptance from requester k, rr_ptr SHALL become (k+1) mod NREQ; NREQ-1 SHALL wrap to 0; with no acceptance rr_ptr SHALL be unchanged.
REQ-012 Latency SHALL be one cycle: a request accepted at edge N SHALL appear on out_data/out_id/out_mode with out_valid=1 immediately after edge N.
REQ-013 Simultaneous drain and load (FULL, out_ready=1, request accepted) SHALL replace the result with no bubble, sustaining one result per cycle.
REQ-014 A requester that drops req_valid without being granted SHALL lose nothing and SHALL NOT move rr_ptr.
REQ-015 All-zero and all-one inputs SHALL convert normally (0->0; 4'b1111 b->g = 4'b1000).

Reset
REQ-016 With rst_n=0 at a rising edge: state=EMPTY, out_valid=0, out_data=0, out_id=0, out_mode=0, rr_ptr=0.
REQ-017 While rst_n=0, req_ready SHALL be all-zero.
REQ-018 Reset mid-operation SHALL discard any held result, with no partial output afterward.

Structure
REQ-019 Package gray_conv_pkg SHALL hold the FSM state type (EMPTY, FULL) and the mode encodings (MODE_B2G=0, MODE_G2B=1).
REQ-020 Conversion SHALL be in one combinational sub-module, gray_xlate (inputs: word, mode; output: converted word); arbitration and FSM SHALL stay in gray_conv_arbiter.

Verification (WIDTH=4, NREQ=4)
REQ-021 Req 0, mode 0, data 4'b1011, out_ready=1 -> next cycle out_valid=1, out_data=4'b1110, out_id=0.
REQ-022 Req 2, mode 1, data 4'b1110 -> out_data=4'b1011, out_id=2, out_mode=1; data 4'b1111 mode 0 -> 4'b1000.
REQ-023 All four req_valid held high, out_ready=1, 5 cycles -> out_id sequence 0,1,2,3,0 (wrap); one result per cycle.
REQ-024 out_ready=0 for 3 cycles while FULL -> req_ready=0, out_data/out_id stable; on out_ready=1 the next grant follows rr_ptr.
REQ-025 rst_n=0 for one edge while FULL with requests pending -> out_valid=0, rr_ptr=0; after release, all valid -> requester 0 granted first.
